hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 IF_DONE  input  1  instruction fetch complete this cycle.
REQ-003 MEM_DONE  input  1  data memory access complete this cycle.
REQ-004 ID_rs1 / ID_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 ID_use_rs1 / ID_use_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 EX_memRead  input  1  instruction in EX is a load.
REQ-007 EX_rd  input  5  destination register of the instruction in EX.
REQ-008 EX_redirect  input  1  EX resolved a branch mispredict or an MRET; PC is redirected.
REQ-009 EX_WFI  input  1  instruction in EX is WFI.
REQ-010 irq_pending  input  1  enabled interrupt pending.
REQ-011 pc_stall, IFID_stall, IFID_flush, IDEX_flush  output  1 each  pipeline control into the PC, IF/ID and ID/EX registers.
REQ-012 sleeping  output  1  core is in WFI sleep.
REQ-013 perf_stall_cnt, perf_flush_cnt  output  32 each  performance counters.

Function
REQ-014 advance SHALL equal IF_DONE && MEM_DONE; the FSM and counters SHALL update only on edges where advance=1.
REQ-015 The FSM states SHALL be HZ_RUN and HZ_SLEEP; sleeping SHALL be 1 exactly in HZ_SLEEP.
REQ-016 Load-use hazard SHALL be EX_memRead && EX_rd!=0 && ((ID_use_rs1 && ID_rs1==EX_rd) || (ID_use_rs2 && ID_rs2==EX_rd)).
REQ-017 In HZ_RUN with a load-use hazard and EX_redirect=0, the block SHALL drive pc_stall=1, IFID_stall=1, IDEX_flush=1, IFID_flush=0 in the same cycle (combinational).
REQ-018 In HZ_RUN with EX_redirect=1, the block SHALL drive IFID_flush=1, IDEX_flush=1, pc_stall=0, IFID_stall=0; redirect SHALL take priority over a load-use hazard.
REQ-019 In HZ_RUN with no hazard and no redirect, all four control outputs SHALL be 0.
REQ-020 HZ_RUN -> HZ_SLEEP SHALL occur on an advancing edge with EX_WFI=1, EX_redirect=0, irq_pending=0; with irq_pending=1, WFI SHALL act as a NOP (stay HZ_RUN).
REQ-021 In HZ_SLEEP, the block SHALL drive pc_stall=1, IFID_stall=1, IDEX_flush=1, IFID_flush=0 every cycle, independent of the ID/EX inputs.
REQ-022 HZ_SLEEP -> HZ_RUN SHALL occur on the first advancing edge with irq_pending=1; outputs SHALL hold the sleep values through that cycle.
REQ-023 With advance=0, outputs SHALL still be computed per REQ-017..021, and the state SHALL hold.

Reset
REQ-024 While rst=1, state SHALL go to HZ_RUN, both counters SHALL go to 0, and every output SHALL read 0 on the following edge and thereafter until rst deasserts.
REQ-025 A reset asserted in HZ_SLEEP SHALL leave the block in HZ_RUN with sleeping=0 after the edge.

Configuration
REQ-026 With HAZARD_PERF_EN defined, perf_stall_cnt SHALL increment on each advancing edge with pc_stall=1, and perf_flush_cnt on each advancing edge with EX_redirect=1 in HZ_RUN, both saturating at 32'hFFFF_FFFF.
REQ-027 Without HAZARD_PERF_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL be synthesized; the ports SHALL remain present.

Structure
REQ-028 Package hazard_pkg SHALL hold the hazard_state_e enum (HZ_RUN, HZ_SLEEP) and the counter width constant (32).
REQ-029 Sub-module hazard_perf_cnt (one saturating counter with enable) SHALL be instantiated twice, only under HAZARD_PERF_EN.

Verification
REQ-030 Load-use: EX_memRead=1, EX_rd=5, ID_rs2=5, ID_use_rs2=1, advance=1 -> pc_stall=IFID_stall=IDEX_flush=1 for one cycle; with EX_rd=0 -> all 0.
REQ-031 Priority: load-use plus EX_redirect=1 in the same cycle -> IFID_flush=IDEX_flush=1, pc_stall=0; perf_flush_cnt +1.
REQ-032 WFI: EX_WFI=1, irq_pending=0, advance=1 -> sleeping=1 next cycle; hold 10 cycles with stall outputs=1; irq_pending=1 -> sleeping=0 one edge later.
REQ-033 Freeze: IF_DONE=0 for 4 cycles during WFI in EX -> state stays HZ_RUN until advance=1; counters unchanged during freeze.
REQ-034 Saturation (HAZARD_PERF_EN, counter forced to 32'hFFFF_FFFE): 3 stall cycles -> perf_stall_cnt=32'hFFFF_FFFF.
REQ-035 Reset in HZ_SLEEP: rst=1 for 1 cycle -> sleeping=0, counters=0, all controls 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
// The HAZARD_PERF_EN macro enables the performance counters in hazard_ctrl.
package hazard_pkg;

  localparam int CNT_W = 32;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_SLEEP = 1'b1
  } hazard_state_e;

  // True when the ID instruction needs the result of a load still in EX.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic       use_rs1,
    input logic [4:0] rs1,
    input logic       use_rs2,
    input logic [4:0] rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Single saturating event counter with enable and synchronous reset.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and WFI sleep.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_DONE,
  input  logic             MEM_DONE,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_memRead,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic             EX_WFI,
  input  logic             irq_pending,
  output logic             pc_stall,
  output logic             IFID_stall,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             sleeping,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  // Handshake: the whole pipeline moves only when both fetch and memory
  // report done in the same cycle; otherwise every register here holds.
  hazard_state_e state_q, state_d;
  logic          advance;
  logic          load_use;

  assign advance  = IF_DONE && MEM_DONE;
  assign load_use = load_use_hazard(EX_memRead, EX_rd, ID_use_rs1, ID_rs1,
                                    ID_use_rs2, ID_rs2);

  // Redirect beats load-use; sleep overrides everything; reset forces all 0.
  always_comb begin
    pc_stall   = 1'b0;
    IFID_stall = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    if (!rst) begin
      if (state_q == HZ_SLEEP) begin
        pc_stall   = 1'b1;
        IFID_stall = 1'b1;
        IDEX_flush = 1'b1;
      end else if (EX_redirect) begin
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        IFID_stall = 1'b1;
        IDEX_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        // A pending interrupt turns WFI into a NOP.
        if (EX_WFI && !EX_redirect && !irq_pending) state_d = HZ_SLEEP;
      end
      HZ_SLEEP: begin
        if (irq_pending) state_d = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else if (advance) begin
      state_q <= state_d;
    end
  end

  assign sleeping = (state_q == HZ_SLEEP);

`ifdef HAZARD_PERF_EN
  logic stall_en;
  logic flush_en;

  assign stall_en = advance && pc_stall;
  assign flush_en = advance && EX_redirect && (state_q == HZ_RUN);

  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (stall_en),
    .cnt_o (perf_stall_cnt)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (flush_en),
    .cnt_o (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared every cycle against a rule-level model of the controller.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        IF_DONE, MEM_DONE;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_memRead, EX_redirect, EX_WFI, irq_pending;
  logic        pc_stall, IFID_stall, IFID_flush, IDEX_flush, sleeping;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .IF_DONE        (IF_DONE),
    .MEM_DONE       (MEM_DONE),
    .ID_rs1         (ID_rs1),
    .ID_rs2         (ID_rs2),
    .ID_use_rs1     (ID_use_rs1),
    .ID_use_rs2     (ID_use_rs2),
    .EX_memRead     (EX_memRead),
    .EX_rd          (EX_rd),
    .EX_redirect    (EX_redirect),
    .EX_WFI         (EX_WFI),
    .irq_pending    (irq_pending),
    .pc_stall       (pc_stall),
    .IFID_stall     (IFID_stall),
    .IFID_flush     (IFID_flush),
    .IDEX_flush     (IDEX_flush),
    .sleeping       (sleeping),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_sleep    = 1'b0;
  bit              m_rst_prev = 1'b0;
  longint unsigned m_stall    = 0;
  longint unsigned m_flush    = 0;

  // {pc_stall, IFID_stall, IFID_flush, IDEX_flush} from the rules.
  function automatic logic [3:0] exp_ctrl(input bit slp);
    bit hz;
    hz = EX_memRead && (EX_rd != 0) &&
         ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
    if (slp)         return 4'b1101;
    if (EX_redirect) return 4'b0011;
    if (hz)          return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] e;
    if (rst) begin
      m_sleep = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else if (IF_DONE && MEM_DONE) begin
      e = exp_ctrl(m_sleep);
      if (e[3]) m_stall = sat_inc(m_stall);
      if (!m_sleep && EX_redirect) m_flush = sat_inc(m_flush);
      if (m_sleep) begin
        if (irq_pending) m_sleep = 1'b0;
      end else if (EX_WFI && !EX_redirect && !irq_pending) begin
        m_sleep = 1'b1;
      end
    end
    m_rst_prev = rst;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0]  act;
    logic [31:0] es, ef;
    act = {pc_stall, IFID_stall, IFID_flush, IDEX_flush};
    if (!rst)            chk("ctrl", {28'd0, act}, {28'd0, exp_ctrl(m_sleep)});
    else if (m_rst_prev) chk("ctrl_rst", {28'd0, act}, 32'd0);
    chk("sleeping", {31'd0, sleeping}, {31'd0, m_sleep});
    es = PERF ? m_stall[31:0] : 32'd0;
    ef = PERF ? m_flush[31:0] : 32'd0;
    chk("stall_cnt", perf_stall_cnt, es);
    chk("flush_cnt", perf_flush_cnt, ef);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_memRead = 0; EX_rd = 0; EX_redirect = 0; EX_WFI = 0; irq_pending = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    EX_memRead = 1; EX_rd = 5; ID_rs2 = 5; ID_use_rs2 = 1;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {28'd0, pc_stall, IFID_stall, IFID_flush, IDEX_flush};
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1; IF_DONE = 1; MEM_DONE = 1;
    clear_ex();
    cyc();
    cyc();
    #2;
    chk("reset_ctrl", ctrl_vec(), 32'd0);
    chk("reset_sleep", {31'd0, sleeping}, 32'd0);
    chk("reset_stall_cnt", perf_stall_cnt, 32'd0);
    rst = 1'b0;
    cyc();

    // load-use stall, then the same with EX_rd = x0
    set_load_use();
    #2 chk("lu_stall", ctrl_vec(), 32'hD);
    cyc();
    EX_rd = 0;
    #2 chk("lu_rd0", ctrl_vec(), 32'h0);
    cyc();
    clear_ex();

    // redirect wins over load-use
    do_reset();
    set_load_use();
    EX_redirect = 1;
    #2 chk("prio_ctrl", ctrl_vec(), 32'h3);
    cyc();
    clear_ex();
    #2;
    chk("prio_flush_cnt", perf_flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("prio_stall_cnt", perf_stall_cnt, 32'd0);

    // WFI sleep, 10 cycles asleep, wake on irq
    cyc();
    EX_WFI = 1;
    cyc();
    EX_WFI = 0;
    #2 chk("wfi_enter", {31'd0, sleeping}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      ID_rs1 = 5'($urandom_range(0, 31)); ID_use_rs1 = 1'($urandom);
      EX_redirect = 1'($urandom); EX_memRead = 1'($urandom);
      #2;
      chk("sleep_hold", {31'd0, sleeping}, 32'd1);
      chk("sleep_ctrl", ctrl_vec(), 32'hD);
    end
    clear_ex();
    irq_pending = 1;
    #2 chk("wake_cycle_ctrl", ctrl_vec(), 32'hD);
    cyc();
    irq_pending = 0;
    #2;
    chk("woken", {31'd0, sleeping}, 32'd0);
    chk("woken_ctrl", ctrl_vec(), 32'd0);

    // freeze while WFI sits in EX, then freeze while asleep
    do_reset();
    IF_DONE = 0;
    EX_WFI = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #2 chk("freeze_run", {31'd0, sleeping}, 32'd0);
    end
    IF_DONE = 1;
    cyc();
    EX_WFI = 0;
    IF_DONE = 0;
    #2 chk("freeze_sleep", {31'd0, sleeping}, 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    #2 chk("freeze_cnt", perf_stall_cnt, 32'd0);
    IF_DONE = 1;
    cyc();
    #2 chk("unfreeze_cnt", perf_stall_cnt, PERF ? 32'd1 : 32'd0);
    irq_pending = 1;
    cyc();
    irq_pending = 0;

`ifdef HAZARD_PERF_EN
    // saturation from a preloaded count
    do_reset();
    #1;
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    m_stall = 64'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt_q;
    set_load_use();
    for (int i = 0; i < 3; i++) cyc();
    clear_ex();
    #2 chk("saturate", perf_stall_cnt, 32'hFFFF_FFFF);
    cyc();
`endif

    // reset while asleep
    EX_WFI = 1;
    cyc();
    EX_WFI = 0;
    #2 chk("pre_rst_sleep", {31'd0, sleeping}, 32'd1);
    rst = 1;
    cyc();
    #2;
    chk("rst_sleep", {31'd0, sleeping}, 32'd0);
    chk("rst_ctrl", ctrl_vec(), 32'd0);
    chk("rst_stall_cnt", perf_stall_cnt, 32'd0);
    chk("rst_flush_cnt", perf_flush_cnt, 32'd0);
    rst = 0;
    cyc();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      IF_DONE     = ($urandom_range(0, 9) < 8);
      MEM_DONE    = ($urandom_range(0, 9) < 8);
      ID_rs1      = 5'($urandom_range(0, 3));
      ID_rs2      = 5'($urandom_range(0, 3));
      ID_use_rs1  = 1'($urandom);
      ID_use_rs2  = 1'($urandom);
      EX_memRead  = 1'($urandom);
      EX_rd       = 5'($urandom_range(0, 3));
      EX_redirect = ($urandom_range(0, 9) == 0);
      EX_WFI      = ($urandom_range(0, 19) == 0);
      irq_pending = ($urandom_range(0, 9) == 0);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
